// File: rtl/fp_sqrt_gen_pkg.sv
// Shared definitions for the fp_sqrt_gen square-root unit:
// FSM state encodings, operand class encodings and the canonical qNaN macro.
`ifndef FP_SQRT_GEN_PKG_SV
`define FP_SQRT_GEN_PKG_SV

// Canonical quiet NaN: positive, all-ones exponent, only the fraction MSB set.
`define FP_SQRT_QNAN(EW, MW) {1'b0, {(EW){1'b1}}, 1'b1, {((MW)-1){1'b0}}}

package fp_sqrt_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ITER,
        ST_ROUND,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } op_class_t;

endpackage

`endif

// File: rtl/fp_sqrt_gen_digit_rec.sv
// Radix-2 restoring square-root recurrence, one root bit per cycle.
// load consumes the top bit pair of rad and resolves the first root bit;
// each step then consumes the next pair. After W-1 steps root holds
// floor(sqrt(rad)) and rem holds rad - root^2.
module sqrt_digit_rec #(
    parameter int W = 26
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [2*W-1:0] rad,
    output logic [W-1:0]   root,
    output logic [W:0]     rem
);

    logic [2*W-3:0] rad_sh;
    logic [1:0]     pair;
    logic [W-1:0]   q_cur;
    logic [W:0]     r_cur;
    logic [W+2:0]   r_sh;
    logic [W+2:0]   trial;
    logic [W-1:0]   q_nxt;
    logic [W:0]     r_nxt;

    // Next root bit: subtract trial (4q+1) from shifted remainder if it fits.
    // The remainder never exceeds 2*root, so W+1 bits always hold it.
    always_comb begin
        pair  = load ? rad[2*W-1:2*W-2] : rad_sh[2*W-3:2*W-4];
        q_cur = load ? '0 : root;
        r_cur = load ? '0 : rem;
        r_sh  = {r_cur, pair};
        trial = {1'b0, q_cur, 2'b01};
        if (r_sh >= trial) begin
            r_nxt = (W+1)'(r_sh - trial);
            q_nxt = {q_cur[W-2:0], 1'b1};
        end else begin
            r_nxt = r_sh[W:0];
            q_nxt = {q_cur[W-2:0], 1'b0};
        end
    end

    // Recurrence state: root, remainder and the unconsumed radicand pairs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            root   <= '0;
            rem    <= '0;
            rad_sh <= '0;
        end else if (load) begin
            root   <= q_nxt;
            rem    <= r_nxt;
            rad_sh <= rad[2*W-3:0];
        end else if (step) begin
            root   <= q_nxt;
            rem    <= r_nxt;
            rad_sh <= {rad_sh[2*W-5:0], 2'b00};
        end
    end

endmodule

// File: rtl/fp_sqrt_gen.sv
// Iterative IEEE-754 square root, round-to-nearest-even, fixed latency LAT.
// Optional macro FP_SQRT_SUBNORMAL_EN: when defined, subnormal inputs are
// normalised with a leading-zero count; otherwise they flush to signed zero.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_UNPACK | classify operand, halve exponent, load recurrence
// ST_ITER   | one root bit per cycle (leading bit already resolved at load)
// ST_ROUND  | round / force special result, register res and flags
// ST_DONE   | done pulse; a start here is accepted
module fp_sqrt_gen
    import fp_sqrt_gen_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [EXP_W+MAN_W:0]     op,
    output logic                     busy,
    output logic                     done,
    output logic [EXP_W+MAN_W:0]     res,
    output logic                     invalid,
    output logic                     inexact
);

    localparam int FW       = EXP_W + MAN_W + 1;
    localparam int BIAS     = 2**(EXP_W-1) - 1;
    localparam int LAT      = MAN_W + 5;
    localparam int ITER_CYC = LAT - 3;
    localparam int W        = MAN_W + 3;
    localparam int CW       = $clog2(LAT);
    localparam int EW       = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic [FW-1:0]        QNAN   = `FP_SQRT_QNAN(EXP_W, MAN_W);

    state_t               state;
    logic [FW-1:0]        op_r;
    op_class_t            cls_r;
    logic [EXP_W-1:0]     exp_res_r;
    logic [CW-1:0]        cnt;

    logic                 sign_u;
    logic [EXP_W-1:0]     exp_u;
    logic [MAN_W-1:0]     frac_u;
    op_class_t            cls_u;
    logic signed [EW-1:0] e_raw;
    logic signed [EW-1:0] e_adj;
    logic [MAN_W+1:0]     sig_raw;
    logic [MAN_W+1:0]     sig_adj;
    logic [EXP_W-1:0]     exp_res_u;
    logic [2*W-1:0]       rad;
    logic [W-1:0]         root;
    logic [W:0]           rem;

    logic                 rnd_up;
    logic                 carry;
    logic                 inexact_c;
    logic [MAN_W:0]       mant;
    logic [MAN_W+1:0]     mant_rnd;
    logic [MAN_W-1:0]     frac_out;
    logic [EXP_W-1:0]     exp_out;
    logic                 flush_sub;

    assign sign_u = op_r[FW-1];
    assign exp_u  = op_r[FW-2:MAN_W];
    assign frac_u = op_r[MAN_W-1:0];

`ifdef FP_SQRT_SUBNORMAL_EN
    localparam int LZW = $clog2(MAN_W + 1);
    logic [LZW-1:0] lzc;
    logic [LZW:0]   sub_sh;

    // Leading-zero count of the fraction; scanning upward lets the top set bit win.
    always_comb begin
        lzc = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (frac_u[i]) lzc = LZW'(MAN_W - 1 - i);
        end
    end

    assign sub_sh    = {1'b0, lzc} + 1'b1;
    assign flush_sub = 1'b0;
`else
    assign flush_sub = (cls_r == CLS_SUB);
`endif

    // Operand classification from the registered operand.
    always_comb begin
        cls_u = CLS_NORM;
        if (exp_u == '1)
            cls_u = (frac_u == '0) ? CLS_INF : (frac_u[MAN_W-1] ? CLS_QNAN : CLS_SNAN);
        else if (exp_u == '0)
            cls_u = (frac_u == '0) ? CLS_ZERO : CLS_SUB;
    end

    // Unbias, make the exponent even by doubling the significand, then halve it.
    always_comb begin
        e_raw   = $signed({2'b00, exp_u}) - BIAS_S;
        sig_raw = {2'b01, frac_u};
`ifdef FP_SQRT_SUBNORMAL_EN
        if (cls_u == CLS_SUB) begin
            sig_raw = {2'b00, frac_u} << sub_sh;
            e_raw   = ONE_S - BIAS_S - $signed(EW'(sub_sh));
        end
`endif
        sig_adj = sig_raw;
        e_adj   = e_raw;
        if (e_raw[0]) begin
            sig_adj = sig_raw << 1;
            e_adj   = e_raw - ONE_S;
        end
        exp_res_u = EXP_W'((e_adj >>> 1) + BIAS_S);
    end

    // Significand in [1,4) with binary point after bit MAN_W, padded so the
    // integer root carries MAN_W fraction bits plus guard and round.
    assign rad = {sig_adj, {(2*W-MAN_W-2){1'b0}}};

    sqrt_digit_rec #(.W(W)) u_rec (
        .clk  (clk),
        .rst  (rst),
        .load (state == ST_UNPACK),
        .step (state == ST_ITER),
        .rad  (rad),
        .root (root),
        .rem  (rem)
    );

    // Round to nearest even on the guard bit, with round|sticky breaking ties.
    always_comb begin
        mant      = root[W-1:2];
        rnd_up    = root[1] & (root[0] | (|rem) | mant[0]);
        mant_rnd  = {1'b0, mant} + (MAN_W+2)'(rnd_up);
        carry     = mant_rnd[MAN_W+1];
        frac_out  = carry ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
        exp_out   = exp_res_r + EXP_W'(carry);
        inexact_c = root[1] | root[0] | (|rem);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_r      <= '0;
            cls_r     <= CLS_ZERO;
            exp_res_r <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res       <= '0;
            invalid   <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_r    <= op;
                        busy    <= 1'b1;
                        invalid <= 1'b0;
                        inexact <= 1'b0;
                        state   <= ST_UNPACK;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_UNPACK: begin
                    cls_r     <= cls_u;
                    exp_res_r <= exp_res_u;
                    cnt       <= CW'(ITER_CYC - 1);
                    state     <= ST_ITER;
                end
                ST_ITER: begin
                    if (cnt == '0) state <= ST_ROUND;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_ROUND: begin
                    if (cls_r == CLS_QNAN) begin
                        res <= QNAN;
                    end else if (cls_r == CLS_SNAN) begin
                        res     <= QNAN;
                        invalid <= 1'b1;
                    end else if (cls_r == CLS_ZERO || flush_sub) begin
                        res <= {sign_u, {(FW-1){1'b0}}};
                    end else if (sign_u) begin
                        res     <= QNAN;
                        invalid <= 1'b1;
                    end else if (cls_r == CLS_INF) begin
                        res <= op_r;
                    end else begin
                        res     <= {1'b0, exp_out, frac_out};
                        inexact <= inexact_c;
                    end
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_gen.sv
// Scoreboard bench for fp_sqrt_gen (binary32). Stimulus pushes the expected
// result and due cycle; the monitor pops and compares on every done pulse.
module tb_fp_sqrt_gen;

    localparam int LAT = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op = '0;
    logic        busy, done, invalid, inexact;
    logic [31:0] res;

    fp_sqrt_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .busy    (busy),
        .done    (done),
        .res     (res),
        .invalid (invalid),
        .inexact (inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          due;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t cur;
    always @(posedge clk) begin
        #1;
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done at cycle %0d, expected none", cyc);
            end else begin
                cur = sb.pop_front();
                check($sformatf("res[%0d]", cur.id), res, cur.res);
                check($sformatf("invalid[%0d]", cur.id), {31'd0, invalid}, {31'd0, cur.inv});
                check($sformatf("inexact[%0d]", cur.id), {31'd0, inexact}, {31'd0, cur.inx});
                check($sformatf("latency[%0d]", cur.id), 32'(cyc), 32'(cur.due));
            end
        end
    end

    // Called at posedge+1; start is sampled by the next edge, done due LAT cycles on.
    task automatic issue(input logic [31:0] v, input logic [31:0] r,
                         input logic inv, input logic inx, input int id);
        exp_t e;
        e.res = r; e.inv = inv; e.inx = inx; e.due = cyc + LAT; e.id = id;
        sb.push_back(e);
        op    = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int id);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout[%0d]: no done within %0d cycles, expected done", id, LAT + 8);
        end
    endtask

    logic [31:0] v_in  [15] = '{32'h40000000, 32'h41100000, 32'hBF800000, 32'h80000000,
                                32'h7F800000, 32'h7F800001, 32'h7FC00001, 32'hFF800000,
                                32'h3E800000, 32'h3F000000, 32'h407FFFFF, 32'h40A00000,
                                32'h00000001, 32'h00000000, 32'h80000001};
`ifdef FP_SQRT_SUBNORMAL_EN
    logic [31:0] v_res [15] = '{32'h3FB504F3, 32'h40400000, 32'h7FC00000, 32'h80000000,
                                32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                                32'h3F000000, 32'h3F3504F3, 32'h3FFFFFFF, 32'h400F1BBD,
                                32'h1A3504F3, 32'h00000000, 32'h7FC00000};
    logic        v_inv [15] = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    logic        v_inx [15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
`else
    logic [31:0] v_res [15] = '{32'h3FB504F3, 32'h40400000, 32'h7FC00000, 32'h80000000,
                                32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                                32'h3F000000, 32'h3F3504F3, 32'h3FFFFFFF, 32'h400F1BBD,
                                32'h00000000, 32'h00000000, 32'h80000000};
    logic        v_inv [15] = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic        v_inx [15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
`endif

    int k;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_res", res, 32'd0);
        check("reset_invalid", {31'd0, invalid}, 32'd0);
        check("reset_inexact", {31'd0, inexact}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 4.0 with busy window check
        k = cyc;
        issue(32'h40800000, 32'h40000000, 1'b0, 1'b0, 100);
        check("busy_cycle1", {31'd0, busy}, 32'd1);
        wait_done(100);
        check("done_cycle", 32'(cyc), 32'(k + LAT));
        check("busy_done_cycle", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("busy_after_done", {31'd0, busy}, 32'd0);

        // directed vector table
        for (int i = 0; i < 15; i++) begin
            issue(v_in[i], v_res[i], v_inv[i], v_inx[i], i);
            wait_done(i);
            @(posedge clk);
            #1;
        end

        // start while busy is ignored
        issue(32'h41100000, 32'h40400000, 1'b0, 1'b0, 200);
        repeat (4) @(posedge clk);
        #1;
        op    = 32'h40800000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200);
        repeat (35) @(posedge clk);
        #1;
        check("busy_after_ignored", {31'd0, busy}, 32'd0);

        // back-to-back start in the done cycle
        k = cyc;
        issue(32'h40800000, 32'h40000000, 1'b0, 1'b0, 300);
        wait_done(300);
        issue(32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 301);
        wait_done(301);
        check("b2b_done_cycle", 32'(cyc), 32'(k + 2 * LAT));
        @(posedge clk);
        #1;

        // reset mid-operation aborts
        issue(32'h41100000, 32'h40400000, 1'b0, 1'b0, 400);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_res", res, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        issue(32'h40A00000, 32'h400F1BBD, 1'b0, 1'b1, 401);
        wait_done(401);
        @(posedge clk);
        #1;

        check("queue_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
